// File: rtl/sc1_uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and lock timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sc1_uart_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_e;

   // Idle cycles a locked owner may sit without a byte before its lock is revoked.
   localparam int LOCK_TIMEOUT_DEFAULT = 4096;

   // The lock timeout counter is never narrower than this.
   localparam int LOCK_CNT_MIN_W = 12;

   // Width of a counter able to hold values up to and including timeout.
   function automatic int lock_cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w > LOCK_CNT_MIN_W) ? w : LOCK_CNT_MIN_W;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter with packet lock in front of a UART transmitter.
// Latency: byte accepted in IDLE, tx_start one cycle later; accept-to-accept >= 4 cycles + busy time.
// Backpressure: reqN_ready high for one IDLE cycle per accepted byte; inputs ignored outside IDLE.
module uart_tx_arbiter
   import sc1_uart_pkg::*;
#(
   parameter int WIDTH_DATA   = 8,
   parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0_valid,
   input  logic [WIDTH_DATA-1:0] req0_data,
   input  logic                  req0_last,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [WIDTH_DATA-1:0] req1_data,
   input  logic                  req1_last,
   output logic                  req1_ready,
   output logic                  tx_start,
   output logic [WIDTH_DATA-1:0] tx_data,
   input  logic                  tx_busy,
   output logic                  grant,
   output logic                  locked
);

   localparam int CNT_W = lock_cnt_width(LOCK_TIMEOUT);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  locked_q, locked_d;
   logic [WIDTH_DATA-1:0] data_q, data_d;
   logic [CNT_W-1:0]      tmo_q, tmo_d;
   logic                  miss_q, miss_d;

   logic                  pick_vld;
   logic                  pick_idx;
   logic                  pick_last;
   logic [WIDTH_DATA-1:0] pick_data;
   logic                  owner_vld;
   logic                  accept;

   // Round-robin pick: a locked owner is the only candidate; otherwise the
   // requester not granted last wins a tie.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = grant_q;
      if (locked_q) begin
         pick_idx = grant_q;
         pick_vld = grant_q ? req1_valid : req0_valid;
      end else if (req0_valid && req1_valid) begin
         pick_idx = ~grant_q;
         pick_vld = 1'b1;
      end else if (req0_valid) begin
         pick_idx = 1'b0;
         pick_vld = 1'b1;
      end else if (req1_valid) begin
         pick_idx = 1'b1;
         pick_vld = 1'b1;
      end
      pick_data = pick_idx ? req1_data : req0_data;
      pick_last = pick_idx ? req1_last : req0_last;
   end

   assign owner_vld = grant_q ? req1_valid : req0_valid;

   // No accept can complete while reset is held, so ready must not claim one.
   assign accept     = (state_q == ST_IDLE) && pick_vld && reset_n;
   assign req0_ready = accept && !pick_idx;
   assign req1_ready = accept &&  pick_idx;

   assign tx_data = data_q;
   assign grant   = grant_q;
   assign locked  = locked_q;

   // Next-state, captured byte, lock and timeout bookkeeping.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      locked_d = locked_q;
      data_d   = data_q;
      tmo_d    = tmo_q;
      miss_d   = miss_q;
      tx_start = 1'b0;

      if (!locked_q) begin
         tmo_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               data_d   = pick_data;
               grant_d  = pick_idx;
               locked_d = ~pick_last;
               tmo_d    = '0;
               state_d  = ST_START;
            end else if (locked_q && !owner_vld) begin
               if (tmo_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  // Revoke the lock. grant keeps the stale owner, which hands
                  // round-robin preference to the other requester.
                  locked_d = 1'b0;
                  tmo_d    = '0;
               end else begin
                  tmo_d = tmo_q + CNT_W'(1);
               end
            end
         end

         ST_START: begin
            tx_start = 1'b1;
            miss_d   = 1'b0;
            state_d  = ST_WAIT_BUSY;
         end

         ST_WAIT_BUSY: begin
            // Give the transmitter two cycles to raise busy; if it never does,
            // assume it missed or already finished the frame.
            if (tx_busy || miss_q) begin
               state_d = ST_WAIT_DONE;
            end else begin
               miss_d = 1'b1;
            end
         end

         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; grant resets to 1 so requester 0 has first priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= 1'b1;
         locked_q <= 1'b0;
         data_q   <= '0;
         tmo_q    <= '0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         locked_q <= locked_d;
         data_q   <= data_d;
         tmo_q    <= tmo_d;
         miss_q   <= miss_d;
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 8, meaning UART byte width.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, meaning idle cycles before a held packet lock is revoked.
REQ-003 SHALL have port clk  input  1  meaning single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  meaning requester has a byte.
REQ-006 SHALL have ports req0_data / req1_data  input  WIDTH_DATA each  meaning requester byte.
REQ-007 SHALL have ports req0_last / req1_last  input  1 each  meaning byte ends the requester's packet.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1 each  meaning byte accepted this cycle.
REQ-009 SHALL have port tx_start  output  1  meaning one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data  output  WIDTH_DATA  meaning byte for the transmitter, stable from tx_start until tx_busy falls.
REQ-011 SHALL have port tx_busy  input  1  meaning transmitter is shifting a frame.
REQ-012 SHALL have port grant  output  1  meaning index of the current or last owner (0/1).
REQ-013 SHALL have port locked  output  1  meaning a packet is in progress and the owner is fixed.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if locked, the SHALL consider only the owner; otherwise it SHALL pick a valid requester round-robin, preferring the one not granted last; on selection, it SHALL capture the data, pulse reqN_ready for one cycle, and go to START.
REQ-016 START: tx_start SHALL be 1 for exactly this one cycle, then go to WAIT_BUSY.
REQ-017 WAIT_BUSY: go to WAIT_DONE when tx_busy=1; if tx_busy stays 0 for 2 cycles, go to WAIT_DONE anyway (transmitter missed or finished).
REQ-018 WAIT_DONE: go to IDLE when tx_busy=0.
REQ-019 Accept-to-next-accept latency SHALL be at least 4 cycles plus the tx_busy high time.
REQ-020 locked SHALL set on an accepted byte with last=0, and SHALL clear on an accepted byte with last=1.
REQ-021 While locked in IDLE, a 12-bit-or-wider counter SHALL count cycles with owner valid=0; at LOCK_TIMEOUT it SHALL clear locked and flip round-robin priority to the other requester.
REQ-022 The timeout counter SHALL reset to 0 on every accept and whenever locked=0.
REQ-023 Simultaneous valid when unlocked: the non-last-granted requester wins; the loser's ready SHALL stay 0.
REQ-024 Only one reqN_ready SHALL be high in any cycle, and only in IDLE.
REQ-025 Requester valid/data/last SHALL be sampled only in IDLE; changes in other states are ignored.

Reset
REQ-026 On reset_n=0 the state SHALL be IDLE and outputs SHALL be: tx_start=0, tx_data=0, req0_ready=0, req1_ready=0, grant=1 (so requester 0 has first priority), locked=0, timeout counter=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no further tx_start; the transmitter's own reset covers the line.
REQ-028 Reset deassertion SHALL be synchronized by the instantiating top; this block SHALL not add a synchronizer.

Structure
REQ-029 FSM state encodings and the default LOCK_TIMEOUT SHALL reside in shared package sc1_uart_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the round-robin pick is combinational logic inside it.
REQ-031 The block SHALL sit between the SoC requesters (CPU, debug monitor) and the existing UART transmitter, with no change to the transmitter.

Verification
REQ-032 Single byte: req0 sends 0x41 with last=1; tx_busy model high for 10 cycles -> one tx_start, tx_data=0x41, req0_ready pulsed once, locked stays 0.
REQ-033 Contention: both valid with 0x11/0x22, last=1, after reset -> order 0x11, 0x22, 0x11, 0x22 alternating.
REQ-034 Packet lock: req1 sends 0xA0,0xA1,0xA2 (last on 0xA2) while req0 is continuously valid -> all three req1 bytes go out contiguously, then a req0 byte.
REQ-035 Timeout: req0 sends 0x55 with last=0, then drops valid; req1 is valid; LOCK_TIMEOUT=16 -> locked clears after 16 idle cycles and the req1 byte is sent next.
REQ-036 Missing busy: tx_busy held 0 -> FSM returns to IDLE within 4 cycles of tx_start, and the next byte issues.
REQ-037 Async reset asserted in WAIT_DONE -> all outputs take REQ-026 values immediately, without waiting for a clock edge.
